// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle between the counter and its surrounding logic.
// The master drives the count controls; the counter is the slave.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  Enable;
    logic                  Up_Down;
    logic                  Load;
    logic [4*DIGITS-1:0]   Load_Value;
    logic [4*DIGITS-1:0]   Count;
    logic                  Terminal;
    logic                  Overflow;

    modport master (
        output Enable, Up_Down, Load, Load_Value,
        input  Count, Terminal, Overflow
    );

    modport slave (
        input  Enable, Up_Down, Load, Load_Value,
        output Count, Terminal, Overflow
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down counter of programmable radix with parallel load,
// wrap or saturate at end of range, terminal-count and overflow flags.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    parameter int WRAP   = 1
) (
    input  logic                 Clock_Div,
    input  logic                 Reset,
    bcd_updown_counter_if.slave  bus
);
    localparam int          W   = 4 * DIGITS;
    localparam logic [3:0]  MAX = 4'(RADIX - 1);

    logic [W-1:0] count_p0;
    logic         ovf_p0;
    logic [W-1:0] count_nxt;
    logic         all_max;
    logic         all_zero;
    logic         end_of_range;

    // Out-of-range load digits are pulled down to the top digit value.
    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > MAX) r[4*i +: 4] = MAX;
        end
        return r;
    endfunction

    always_comb begin : step_logic
        logic       carry;
        logic [3:0] d;
        logic [3:0] nd;
        carry     = 1'b1;
        d         = 4'd0;
        nd        = 4'd0;
        count_nxt = count_p0;
        all_max   = 1'b1;
        all_zero  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_p0[4*i +: 4];
            if (d != MAX)  all_max  = 1'b0;
            if (d != 4'd0) all_zero = 1'b0;
            if (carry) begin
                if (bus.Up_Down) nd = (d == MAX)  ? 4'd0 : 4'(d + 4'd1);
                else             nd = (d == 4'd0) ? MAX  : 4'(d - 4'd1);
                count_nxt[4*i +: 4] = nd;
                carry = bus.Up_Down ? (d == MAX) : (d == 4'd0);
            end
        end
    end

    assign end_of_range = bus.Up_Down ? all_max : all_zero;

    // Register stage: load beats enable; a blocked end-of-range step still flags overflow.
    always_ff @(posedge Clock_Div or negedge Reset) begin
        if (!Reset) begin
            count_p0 <= '0;
            ovf_p0   <= 1'b0;
        end else if (bus.Load) begin
            count_p0 <= clamp_load(bus.Load_Value);
            ovf_p0   <= 1'b0;
        end else if (bus.Enable) begin
            if (end_of_range) begin
                ovf_p0 <= 1'b1;
                if (WRAP != 0) count_p0 <= count_nxt;
            end else begin
                count_p0 <= count_nxt;
                ovf_p0   <= 1'b0;
            end
        end else begin
            ovf_p0 <= 1'b0;
        end
    end

    assign bus.Count    = count_p0;
    assign bus.Overflow = ovf_p0;
    assign bus.Terminal = end_of_range;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed-vector bench for a 2-digit decimal counter, wrap and saturate variants
// side by side; expectations flow through a queue to an independent monitor.
module tb_bcd_updown_counter;
    typedef struct {
        logic [7:0] c;
        logic       o;
        logic       t;
        int         sel;
        int         id;
        bit         is_async;
    } exp_t;

    logic Clock_Div = 1'b0;
    logic Reset     = 1'b0;
    always #5 Clock_Div = ~Clock_Div;

    bcd_updown_counter_if #(.DIGITS(2)) bw ();
    bcd_updown_counter_if #(.DIGITS(2)) bs ();

    bcd_updown_counter #(.DIGITS(2), .RADIX(10), .WRAP(1)) u_wrap (
        .Clock_Div (Clock_Div),
        .Reset     (Reset),
        .bus       (bw.slave)
    );

    bcd_updown_counter #(.DIGITS(2), .RADIX(10), .WRAP(0)) u_sat (
        .Clock_Div (Clock_Div),
        .Reset     (Reset),
        .bus       (bs.slave)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   vid   = 0;
    event async_ev;

    logic [7:0] up_seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

    task automatic compare(input exp_t e);
        logic [7:0] c;
        logic       o;
        logic       t;
        if (e.sel == 0) begin c = bw.Count; o = bw.Overflow; t = bw.Terminal; end
        else            begin c = bs.Count; o = bs.Overflow; t = bs.Terminal; end
        total += 3;
        if (c !== e.c) begin
            bad++;
            $display("FAIL vec%0d dut%0d count got=%h want=%h", e.id, e.sel, c, e.c);
        end
        if (o !== e.o) begin
            bad++;
            $display("FAIL vec%0d dut%0d overflow got=%b want=%b", e.id, e.sel, o, e.o);
        end
        if (t !== e.t) begin
            bad++;
            $display("FAIL vec%0d dut%0d terminal got=%b want=%b", e.id, e.sel, t, e.t);
        end
    endtask

    // Edge-aligned monitor
    initial forever begin
        @(posedge Clock_Div);
        #2;
        if (q.size() > 0 && !q[0].is_async) compare(q.pop_front());
    end

    // Monitor for checks that must not wait for an edge
    initial forever begin
        @(async_ev);
        #1;
        if (q.size() > 0 && q[0].is_async) compare(q.pop_front());
    end

    task automatic step(input logic rst, input logic en, input logic ud, input logic ld,
                        input logic [7:0] lv, input logic [7:0] ec, input logic eo,
                        input logic et, input int sel);
        exp_t e;
        @(negedge Clock_Div);
        Reset = rst;
        bw.Enable = en; bw.Up_Down = ud; bw.Load = ld; bw.Load_Value = lv;
        bs.Enable = en; bs.Up_Down = ud; bs.Load = ld; bs.Load_Value = lv;
        e.c = ec; e.o = eo; e.t = et; e.sel = sel; e.id = vid; e.is_async = 1'b0;
        vid++;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        bw.Enable = 1'b0; bw.Up_Down = 1'b1; bw.Load = 1'b0; bw.Load_Value = 8'h00;
        bs.Enable = 1'b0; bs.Up_Down = 1'b1; bs.Load = 1'b0; bs.Load_Value = 8'h00;

        // reset held, then count up from zero
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 8'h00, up_seq[i], 0, 0, 0);

        // up-wrap
        step(1, 0, 1, 1, 8'h98, 8'h98, 0, 0, 0);
        step(1, 1, 1, 0, 8'h00, 8'h99, 0, 1, 0);
        step(1, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0);
        step(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);

        // down-wrap then direction change at the bottom of range
        step(1, 0, 0, 1, 8'h01, 8'h01, 0, 0, 0);
        step(1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 1, 0, 0, 8'h00, 8'h99, 1, 0, 0);
        step(1, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0);

        // load clamp beats enable and clears overflow
        step(1, 1, 1, 1, 8'hAF, 8'h99, 0, 1, 0);

        // saturate variant, up then down
        step(1, 0, 1, 1, 8'h99, 8'h99, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 8'h00, 8'h99, 1, 1, 1);
        step(1, 0, 1, 0, 8'h00, 8'h99, 0, 1, 1);
        step(1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1);
        step(1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 1);
        step(1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 1);

        // borrow across digits
        step(1, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
        step(1, 1, 0, 0, 8'h00, 8'h09, 0, 0, 0);

        // count to 47, hold, then resume
        step(1, 0, 1, 1, 8'h45, 8'h45, 0, 0, 0);
        step(1, 1, 1, 0, 8'h00, 8'h46, 0, 0, 0);
        step(1, 1, 1, 0, 8'h00, 8'h47, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'h00, 8'h47, 0, 0, 0);
        step(1, 1, 1, 0, 8'h00, 8'h48, 0, 0, 0);

        // asynchronous reset between edges
        @(posedge Clock_Div);
        #3;
        Reset = 1'b0;
        e.c = 8'h00; e.o = 1'b0; e.t = 1'b0; e.sel = 0; e.id = vid; e.is_async = 1'b1;
        vid++;
        q.push_back(e);
        ->async_ev;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clock_Div);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit up/down counter that generalises the single-digit hex counter to DIGITS cascaded digits of programmable radix. It adds count enable, parallel load, wrap or saturate mode, and terminal-count and overflow flags. It sits between the frequency divider, which supplies Clock_Div, and the per-digit seven-segment decoders, which each consume one 4-bit slice of Count.

## Interface
- DIGITS, default 4: number of cascaded digits, 1..8.
- RADIX, default 10: modulus of every digit, 2..16. With RADIX=16 the block is a plain hex counter.
- WRAP, default 1: 1 wraps at the end of range; 0 saturates.

Ports (name, direction, width, meaning):
- Clock_Div, input, 1: counting clock. All state updates on its rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Enable, input, 1: count enable, sampled on the rising edge.
- Up_Down, input, 1: 1 counts up, 0 counts down.
- Load, input, 1: synchronous parallel load, sampled on the rising edge.
- Load_Value, input, 4*DIGITS: load data. Digit i is bits [4i+3:4i].
- Count, output, 4*DIGITS: registered count. Digit 0 is the least significant digit, bits [3:0].
- Terminal, output, 1: combinational end-of-range flag.
- Overflow, output, 1: registered one-cycle flag marking an end-of-range step.

## Operation
- Reset asserted (Reset=0): Count=0 and Overflow=0 immediately, regardless of the clock. Reset takes effect mid-count with no glitch to intermediate values.
- Priority at each rising edge, in order:
  1. Load
  2. Enable
  3. hold
- Load=1:
  - Each digit takes its Load_Value digit, clamped to RADIX-1 if it is >= RADIX.
  - Overflow=0.
  - Load overrides Enable and Up_Down.
- Enable=1, Up_Down=1:
  - Digit 0 increments.
  - Digit i increments only when all lower digits equal RADIX-1.
  - A digit at RADIX-1 that increments becomes 0.
- Enable=1, Up_Down=0:
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits equal 0.
  - A digit at 0 that decrements becomes RADIX-1.
- End of range is all digits at RADIX-1 going up, or all digits at 0 going down. A step taken at end of range:
  - WRAP=1: the count wraps to all-zero (up) or all-(RADIX-1) (down). Overflow=1 for the following cycle.
  - WRAP=0: the count holds. Overflow=1 for the following cycle, and stays 1 on every further blocked step.
- Enable=0 and Load=0: Count holds and Overflow=0.
- Terminal = (Up_Down=1 and all digits are RADIX-1) or (Up_Down=0 and all digits are 0).
  - Terminal is independent of Enable.
  - Terminal follows Up_Down combinationally.
- Digit arithmetic is 4-bit unsigned. Digit values >= RADIX can only enter via Load, and Load clamps them, so they never appear on Count.
- Up_Down may change on any cycle. The new direction applies from the next enabled edge, with no dead cycle.

## Timing
- Count latency: 1 edge from sampling Enable, Load or Up_Down.
- Overflow is registered and aligned with the edge that produced the wrapped (or held) Count. It is high for exactly one Clock_Div period per end-of-range step.
- Terminal is combinational from Count and Up_Down, so it is valid in the same cycle as Count.
- Carry and borrow ripple combinationally across all DIGITS within one cycle. Every digit updates on the same edge.
- Reset deassertion is expected to be synchronised upstream. The first count edge after release increments from 0.

## Test plan
All scenarios use DIGITS=2, RADIX=10 unless stated.

- Reset then count up:
  - Stimulus: hold Reset=0 for 3 edges, then Reset=1, Enable=1, Up_Down=1 for 12 edges.
  - Required response: Count=0x00 during reset, then 0x01…0x09, 0x10, 0x11, 0x12. Overflow stays 0.
- Up-wrap:
  - Stimulus: load 0x98, then count up 2 edges.
  - Required response: Count goes 0x99 (Terminal=1), then 0x00 with Overflow=1 for one cycle, then Overflow=0.
- Down-wrap and direction change:
  - Stimulus: load 0x01, count down 2 edges, then set Up_Down=1 for 1 edge.
  - Required response: Count goes 0x00 (Terminal=1), then 0x99 with Overflow=1, then 0x00.
- Load clamp and priority:
  - Stimulus: Load_Value=0xAF with Load=1 and Enable=1 on the same edge.
  - Required response: Count=0x99, Overflow=0, and the count does not increment on that edge.
- Saturate mode:
  - Stimulus: WRAP=0, load 0x99, count up 3 edges.
  - Required response: Count stays 0x99 and Overflow=1 on each of the 3 cycles. Down from 0x00 holds 0x00 in the same way.
- Hold and asynchronous reset mid-count:
  - Stimulus: count to 0x47, drop Enable for 5 edges, then pull Reset low between edges.
  - Required response: Count=0x47 while Enable is low. Count=0x00 immediately on Reset assertion, without waiting for an edge.
